// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU IO write decode and a UART transmitter.
// A three-state drain FSM pops one byte at a time and pulses a start strobe.
module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_strobe_i,
  input  logic [7:0]         wr_data_i,
  input  logic               clr_overflow_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               overflow_o,
  output logic               uart_wr_strobe_o,
  output logic [7:0]         uart_data_o,
  input  logic               uart_busy_i
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic               uart_strobe;
  logic [7:0]         uart_data;
  state_t             state;

  logic push_ok;
  logic push_drop;
  logic pop;

  // Flags decode only registered state, so wr_strobe_i never reaches them combinationally.
  assign full_o  = (level == LEVEL_W'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;

  assign overflow_o       = overflow;
  assign uart_wr_strobe_o = uart_strobe;
  assign uart_data_o      = uart_data;

  assign push_ok   = wr_strobe_i && !full_o;
  assign push_drop = wr_strobe_i && full_o;
  assign pop       = (state == S_IDLE) && !empty_o && !uart_busy_i;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A dropped push on the same edge beats a clear request.
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow_i) begin
        overflow <= 1'b0;
      end
    end
  end

  // The guard state gives the UART one cycle to raise busy after the strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      uart_strobe <= 1'b0;
      uart_data   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          uart_strobe <= 1'b0;
          if (pop) begin
            uart_data   <= mem[rd_ptr];
            uart_strobe <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          uart_strobe <= 1'b0;
          state       <= S_GUARD;
        end
        S_GUARD: begin
          uart_strobe <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          uart_strobe <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a cycle table for basic push/pop/drain timing
// plus hand-written sequences for overflow, wrap-around and mid-transfer reset.
module tb_uart_tx_fifo;

  localparam int DEPTH   = 16;
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               wr_strobe_i;
  logic [7:0]         wr_data_i;
  logic               clr_overflow_i;
  logic               full_o;
  logic               empty_o;
  logic [LEVEL_W-1:0] level_o;
  logic               overflow_o;
  logic               uart_wr_strobe_o;
  logic [7:0]         uart_data_o;
  logic               uart_busy_i;

  uart_tx_fifo #(.DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .wr_strobe_i      (wr_strobe_i),
    .wr_data_i        (wr_data_i),
    .clr_overflow_i   (clr_overflow_i),
    .full_o           (full_o),
    .empty_o          (empty_o),
    .level_o          (level_o),
    .overflow_o       (overflow_o),
    .uart_wr_strobe_o (uart_wr_strobe_o),
    .uart_data_o      (uart_data_o),
    .uart_busy_i      (uart_busy_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       wr;
    logic [7:0] data;
    logic       busy;
    logic       clr;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       strobe;
    logic [7:0] udata;
  } vec_t;

  vec_t vecs [16];

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] cap_q [$];
  int cycle_cnt   = 0;
  int last_strobe = -100;
  int min_gap     = 1000;

  // Records every transmitted byte and the tightest spacing between strobes.
  always @(negedge clk_i) begin
    cycle_cnt++;
    if (uart_wr_strobe_o === 1'b1) begin
      cap_q.push_back(uart_data_o);
      if (cycle_cnt - last_strobe < min_gap) min_gap = cycle_cnt - last_strobe;
      last_strobe = cycle_cnt;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic busy, input logic clr);
    wr_strobe_i    = wr;
    wr_data_i      = data;
    uart_busy_i    = busy;
    clr_overflow_i = clr;
    step();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " level"},  32'(level_o), 32'd0);
    checkOutput({tag, " empty"},  32'(empty_o), 32'd1);
    checkOutput({tag, " full"},   32'(full_o), 32'd0);
    checkOutput({tag, " ovf"},    32'(overflow_o), 32'd0);
    checkOutput({tag, " strobe"}, 32'(uart_wr_strobe_o), 32'd0);
    checkOutput({tag, " udata"},  32'(uart_data_o), 32'h00);
  endtask

  initial begin
    int waited;

    rst_i          = 1'b1;
    wr_strobe_i    = 1'b0;
    wr_data_i      = 8'h00;
    clr_overflow_i = 1'b0;
    uart_busy_i    = 1'b0;

    // Expected outputs are those seen just after the edge the vector was applied to.
    //               wr    data   busy  clr   level empty full  ovf   strb  udata
    vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41};
    vecs[4]  = '{1'b1, 8'hA1, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41};
    vecs[5]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41};
    vecs[6]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA2};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA2};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA3};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA3};

    repeat (3) @(negedge clk_i);
    checkResetValues("reset");
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].busy, vecs[i].clr);
      checkOutput($sformatf("vec%0d level", i),  32'(level_o), 32'(vecs[i].level));
      checkOutput($sformatf("vec%0d empty", i),  32'(empty_o), 32'(vecs[i].empty));
      checkOutput($sformatf("vec%0d full", i),   32'(full_o), 32'(vecs[i].full));
      checkOutput($sformatf("vec%0d ovf", i),    32'(overflow_o), 32'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d strobe", i), 32'(uart_wr_strobe_o), 32'(vecs[i].strobe));
      checkOutput($sformatf("vec%0d udata", i),  32'(uart_data_o), 32'(vecs[i].udata));
    end

    // Fill with busy held, overflow, clear-vs-set priority, push+pop on a full FIFO.
    for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
    checkOutput("fill full",  32'(full_o), 32'd1);
    checkOutput("fill level", 32'(level_o), 32'd16);
    checkOutput("fill ovf",   32'(overflow_o), 32'd1);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1);
    checkOutput("clr+drop ovf",   32'(overflow_o), 32'd1);
    checkOutput("clr+drop level", 32'(level_o), 32'd16);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("clr alone ovf", 32'(overflow_o), 32'd0);
    cap_q.delete();
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("push+pop full level", 32'(level_o), 32'd15);
    checkOutput("push+pop full ovf",   32'(overflow_o), 32'd1);
    checkOutput("push+pop full strobe", 32'(uart_wr_strobe_o), 32'd1);
    wr_strobe_i = 1'b0;
    waited = 0;
    while (!(cap_q.size() >= 16 && empty_o === 1'b1) && waited < 200) begin
      step();
      waited++;
    end
    repeat (4) step();
    checkOutput("drain timeout", 32'(waited < 200), 32'd1);
    checkOutput("drain count",   32'(cap_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < cap_q.size(); i++)
      checkOutput($sformatf("drain byte%0d", i), 32'(cap_q[i]), 32'(i));
    checkOutput("drain empty", 32'(empty_o), 32'd1);

    // Streaming across pointer wrap-around at one push per three cycles.
    cap_q.delete();
    min_gap = 1000;
    last_strobe = -100;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    repeat (20) step();
    checkOutput("stream count", 32'(cap_q.size()), 32'd40);
    for (int i = 0; i < 40 && i < cap_q.size(); i++)
      checkOutput($sformatf("stream byte%0d", i), 32'(cap_q[i]), 32'(8'h20 + i));
    checkOutput("stream gap>=3", 32'(min_gap >= 3), 32'd1);
    checkOutput("stream empty",  32'(empty_o), 32'd1);

    // Asynchronous reset while the strobe is high, five bytes queued.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    wr_strobe_i = 1'b0;
    uart_busy_i = 1'b0;
    waited = 0;
    while (uart_wr_strobe_o !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    checkOutput("issue reached", 32'(uart_wr_strobe_o), 32'd1);
    #2 rst_i = 1'b1;
    #1 checkResetValues("async rst");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    cap_q.delete();
    repeat (20) step();
    checkOutput("no strobe after rst", 32'(cap_q.size()), 32'd0);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    wr_strobe_i = 1'b0;
    repeat (5) step();
    checkOutput("post-rst count", 32'(cap_q.size()), 32'd1);
    if (cap_q.size() > 0) checkOutput("post-rst byte", 32'(cap_q[0]), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO capacity in bytes (power of two, 2..256).
REQ-002 SHALL have parameter LEVEL_W, default $clog2(DEPTH)+1, width of level_o.
REQ-003 SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_strobe_i  input  1  one-cycle push request from the CPU IO write decode.
REQ-006 SHALL have port wr_data_i  input  8  byte to push, sampled with wr_strobe_i.
REQ-007 SHALL have port clr_overflow_i  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port full_o  output  1  FIFO holds DEPTH bytes.
REQ-009 SHALL have port empty_o  output  1  FIFO holds 0 bytes.
REQ-010 SHALL have port level_o  output  LEVEL_W  current byte count, 0..DEPTH.
REQ-011 SHALL have port overflow_o  output  1  sticky: a push was dropped.
REQ-012 SHALL have port uart_wr_strobe_o  output  1  one-cycle start-transmit pulse to the UART transmitter.
REQ-013 SHALL have port uart_data_o  output  8  byte to transmit, valid while uart_wr_strobe_o is high.
REQ-014 SHALL have port uart_busy_i  input  1  UART transmitter busy.

Function
REQ-015 SHALL store bytes in a DEPTH-entry circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 SHALL accept a push when wr_strobe_i=1 and full_o=0; the byte is written at the write pointer and the level increments on that edge.
REQ-017 SHALL drop a push when wr_strobe_i=1 and full_o=1, leave the contents unchanged, and set overflow_o on that edge, even if a pop occurs in the same cycle.
REQ-018 SHALL clear overflow_o on an edge with clr_overflow_i=1, unless a dropped push occurs on the same edge; in that case set wins.
REQ-019 SHALL leave level_o unchanged when a push and a pop occur on the same edge, with both pointers advancing.
REQ-020 SHALL drive full_o, empty_o and level_o as registered or pure decodes of registered state, with no combinational path from wr_strobe_i.
REQ-021 SHALL implement the drain FSM with states S_IDLE, S_ISSUE and S_GUARD.
REQ-022 In S_IDLE, when empty_o=0 and uart_busy_i=0, the FSM SHALL pop the head byte, register it into uart_data_o, and go to S_ISSUE; otherwise it SHALL stay in S_IDLE.
REQ-023 In S_ISSUE, uart_wr_strobe_o SHALL be 1 for exactly that cycle, and the FSM SHALL go unconditionally to S_GUARD.
REQ-024 In S_GUARD, the FSM SHALL ignore uart_busy_i for one cycle (this covers busy rising one cycle late) and then return to S_IDLE.
REQ-025 SHALL hold uart_wr_strobe_o at 0 in S_IDLE and S_GUARD, so that at most one strobe is issued per 3 cycles.
REQ-026 SHALL hold uart_data_o stable from the pop until the next pop.
REQ-027 SHALL issue the strobe 2 cycles after a push into an empty FIFO with the UART idle: push on edge N, pop/register on edge N+1, strobe high during the cycle after edge N+2 is not used; the strobe is high between edges N+1 and N+2.
REQ-028 SHALL transmit bytes in push order, with no loss and no duplication, across pointer wrap-around.

Reset
REQ-029 While rst_i=1, regardless of clock: pointers=0, level_o=0, empty_o=1, full_o=0, overflow_o=0, uart_wr_strobe_o=0, uart_data_o=8'h00, FSM=S_IDLE.
REQ-030 On reset asserted mid-operation (including during S_ISSUE), all buffered bytes SHALL be discarded and no further strobe issued until new data is pushed after reset release.
REQ-031 Buffer RAM contents need no reset.

Verification
REQ-032 Push 8'h41 into an empty FIFO, busy=0 -> exactly one strobe with data 8'h41, level returns to 0, empty_o=1.
REQ-033 Hold busy=1 and push DEPTH+1 bytes 0..16 -> full_o=1, level_o=16, overflow_o=1; after busy is released, bytes 0..15 are transmitted in order and byte 16 is never sent.
REQ-034 Keep busy=0 and push continuously for 40 bytes at 1 per 3 cycles -> all 40 bytes are sent in order across wrap-around, with strobes spaced at least 3 cycles apart.
REQ-035 With full_o=1, drive a push and a pop on the same edge -> the push is dropped, overflow_o=1, level_o=15.
REQ-036 Assert clr_overflow_i together with a dropped push -> overflow_o stays 1; assert clr_overflow_i alone on the next edge -> overflow_o=0.
REQ-037 Assert rst_i asynchronously during S_ISSUE with 5 bytes queued -> outputs take their reset values immediately, and no strobe occurs after release until a new push.
